fp_sigmoid_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one pipelined sigmoid unit (fpSigmoid) among NREQ requesters. It accepts one operand per cycle, tracks each operation's owner with a tag pipeline matched to the unit latency, and returns each result to its owner through a one-entry response buffer with a valid/ready handshake. It also gates the unit's clock enable when no operation is in flight.

---
 rtl/fp_sigmoid_arb_pkg.sv | 16 +
 rtl/rr_arbiter_oh.sv | 30 +++
 rtl/fp_sigmoid_arb.sv | 114 +++++++++++
 tb/tb_fp_sigmoid_arb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sigmoid_arb_pkg.sv
// Shared types and configuration checks for the sigmoid-unit arbiter.
// Tag ids are sized for the largest supported requester count (8).
package fp_sigmoid_arb_pkg;

  localparam int TAG_IDW = 3;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  function automatic bit cfg_ok(input int nreq, input int lat);
    return (lat >= 1) && (nreq >= 2) && (nreq <= 8);
  endfunction

endpackage

// File: rtl/rr_arbiter_oh.sv
// Round-robin pick: first asserted request at or above i_ptr, wrapping; one-hot plus index.
// Purely combinational, zero latency; no request means no grant and o_idx = 0.
module rr_arbiter_oh #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx
);

  always_comb begin
    int   v_idx;
    logic v_found;
    o_gnt   = '0;
    o_idx   = '0;
    v_found = 1'b0;
    v_idx   = 0;
    for (int off = 0; off < NREQ; off++) begin
      v_idx = (int'(i_ptr) + off) % NREQ;
      if (!v_found && i_req[v_idx]) begin
        v_found      = 1'b1;
        o_gnt[v_idx] = 1'b1;
        o_idx        = IDW'(v_idx);
      end
    end
  end

endmodule

// File: rtl/fp_sigmoid_arb.sv
// Shares one pipelined sigmoid unit among NREQ requesters; result returns LAT+1 edges after accept.
// One outstanding op per requester; a held response blocks only its owner, never the unit.
module fp_sigmoid_arb
  import fp_sigmoid_arb_pkg::*;
#(
  parameter int FPWID = 32,
  parameter int NREQ  = 4,
  parameter int LAT   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*FPWID-1:0]  req_a,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [NREQ*FPWID-1:0]  rsp_o,
  output logic [FPWID-1:0]       sig_a,
  output logic                   sig_ce,
  input  logic [FPWID-1:0]       sig_o,
  output logic                   busy
);

  localparam int IDW = $clog2(NREQ);

  if (!cfg_ok(NREQ, LAT)) begin : g_cfg_err
    $error("fp_sigmoid_arb: unsupported NREQ/LAT combination");
  end

  logic [NREQ-1:0]       r_pend;
  logic [IDW-1:0]        r_ptr;
  logic [FPWID-1:0]      r_sig_a;
  tag_t                  r_tag [LAT];
  tag_t                  r_cap;
  logic [NREQ-1:0]       r_rsp_valid;
  logic [NREQ*FPWID-1:0] r_rsp_o;

  logic [NREQ-1:0]       w_elig;
  logic [NREQ-1:0]       w_gnt;
  logic [IDW-1:0]        w_gnt_idx;
  logic                  w_accept;
  logic                  w_ce;

  assign w_elig = req_valid & ~r_pend;

  rr_arbiter_oh #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx)
  );

  // Gate with rst_n so req_ready is 0 while reset is held, not just after it.
  assign w_accept  = rst_n & (|w_gnt);
  assign req_ready = rst_n ? w_gnt : '0;

  always_comb begin
    w_ce = 1'b0;
    for (int s = 0; s < LAT; s++) w_ce = w_ce | r_tag[s].valid;
  end

  // r_cap trails the last unit stage by one edge: sig_o is valid while r_cap is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) r_tag[s] <= '0;
      r_cap   <= '0;
      r_sig_a <= '0;
      r_ptr   <= '0;
    end else begin
      r_tag[0].valid <= w_accept;
      r_tag[0].id    <= TAG_IDW'(w_gnt_idx);
      if (w_ce) begin
        for (int s = 1; s < LAT; s++) r_tag[s] <= r_tag[s-1];
      end
      r_cap <= r_tag[LAT-1];
      if (w_accept) begin
        r_sig_a <= req_a[int'(w_gnt_idx)*FPWID +: FPWID];
        r_ptr   <= (int'(w_gnt_idx) == NREQ-1) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= '0;
      r_rsp_valid <= '0;
      r_rsp_o     <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_accept && w_gnt[i]) begin
          r_pend[i] <= 1'b1;
        end else if (r_rsp_valid[i] && rsp_ready[i]) begin
          r_pend[i] <= 1'b0;
        end
        if (r_cap.valid && (int'(r_cap.id) == i)) begin
          r_rsp_valid[i]             <= 1'b1;
          r_rsp_o[i*FPWID +: FPWID]  <= sig_o;
        end else if (r_rsp_valid[i] && rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign sig_a     = r_sig_a;
  assign sig_ce    = w_ce;
  assign rsp_valid = r_rsp_valid;
  assign rsp_o     = r_rsp_o;
  assign busy      = |r_pend;

endmodule

// File: tb/tb_fp_sigmoid_arb.sv
// Bench for fp_sigmoid_arb with an inverting LAT-cycle unit model and an event-level
// scoreboard that predicts grants, response timing, sig_ce and busy every cycle.
module tb_fp_sigmoid_arb;

  localparam int FPWID = 32;
  localparam int NREQ  = 4;
  localparam int LAT   = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*FPWID-1:0] req_a = '0;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready = '1;
  logic [NREQ*FPWID-1:0] rsp_o;
  logic [FPWID-1:0]      sig_a;
  logic                  sig_ce;
  logic [FPWID-1:0]      sig_o;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_sigmoid_arb #(.FPWID(FPWID), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_o     (rsp_o),
    .sig_a     (sig_a),
    .sig_ce    (sig_ce),
    .sig_o     (sig_o),
    .busy      (busy)
  );

  // Sigmoid stand-in: bitwise inverse, LAT stages that advance only under sig_ce.
  logic [LAT*FPWID-1:0] u_pipe = '0;
  always @(posedge clk) if (sig_ce) u_pipe <= {u_pipe[(LAT-1)*FPWID-1:0], sig_a};
  assign sig_o = ~u_pipe[LAT*FPWID-1 -: FPWID];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: per requester, whether an op is outstanding, the edge it was accepted
  // on and the value it must return; plus the rotating priority start.
  logic [NREQ-1:0]  m_pend = '0;
  int               m_ptr = 0;
  int               m_acc [NREQ];
  logic [FPWID-1:0] m_val [NREQ];
  logic [FPWID-1:0] m_sig_a = '0;
  int               cyc = 0;
  int               m_g;
  logic [NREQ-1:0]  m_hs;
  bit               mon_on = 1'b0;

  function automatic int pick(input logic [NREQ-1:0] elig, input int ptr);
    for (int k = 0; k < NREQ; k++) if (elig[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_grant();
    logic [NREQ-1:0] r = '0;
    int g = pick(req_valid & ~m_pend, m_ptr);
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [NREQ-1:0] exp_rv();
    logic [NREQ-1:0] r = '0;
    for (int i = 0; i < NREQ; i++) r[i] = m_pend[i] && (cyc >= m_acc[i] + LAT + 1);
    return r;
  endfunction

  function automatic logic exp_ce();
    logic r = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (m_pend[i] && cyc >= m_acc[i] && cyc <= m_acc[i] + LAT - 1) r = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend  = '0;
      m_ptr   = 0;
      m_sig_a = '0;
      cyc     = 0;
    end else begin
      m_hs = exp_rv() & rsp_ready;
      m_g  = pick(req_valid & ~m_pend, m_ptr);
      cyc++;
      m_pend = m_pend & ~m_hs;
      if (m_g >= 0) begin
        m_pend[m_g] = 1'b1;
        m_acc[m_g]  = cyc;
        m_val[m_g]  = ~req_a[m_g*FPWID +: FPWID];
        m_sig_a     = req_a[m_g*FPWID +: FPWID];
        m_ptr       = (m_g + 1) % NREQ;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (!rst_n) begin
        chk("rst_outputs", {req_ready, rsp_valid, sig_ce, busy, sig_a}, '0);
        chk("rst_rsp_o", rsp_o, '0);
      end else begin
        chk("req_ready", req_ready, exp_grant());
        chk("rsp_valid", rsp_valid, exp_rv());
        for (int i = 0; i < NREQ; i++)
          if (exp_rv()[i]) chk($sformatf("rsp_o[%0d]", i), rsp_o[i*FPWID +: FPWID], m_val[i]);
        chk("sig_ce", sig_ce, exp_ce());
        chk("busy", busy, |m_pend);
        chk("sig_a", sig_a, m_sig_a);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = '1;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] exp_o;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int lat;
    int cnt_other;
    int last;
    int ngr;
    int g;

    tbl[0] = '{2, 32'h3F800000, 32'hC07FFFFF};
    tbl[1] = '{0, 32'h00000000, 32'hFFFFFFFF};
    tbl[2] = '{1, 32'hBF800000, 32'h407FFFFF};
    tbl[3] = '{3, 32'h7F7FFFFF, 32'h80800000};
    tbl[4] = '{3, 32'h12345678, 32'hEDCBA987};
    tbl[5] = '{0, 32'hFFFFFFFF, 32'h00000000};

    mon_on = 1'b1;
    do_reset();

    // Single requests: only one eligible, so it is granted regardless of pointer.
    for (int v = 0; v < 6; v++) begin
      tick();
      req_a = '0;
      req_a[tbl[v].id*FPWID +: FPWID] = tbl[v].a;
      req_valid = NREQ'(1) << tbl[v].id;
      settle();
      chk($sformatf("vec%0d_grant", v), req_ready, NREQ'(1) << tbl[v].id);
      tick();
      req_valid = '0;
      lat = 0;
      while (!rsp_valid[tbl[v].id] && lat < 10) begin
        tick();
        lat++;
      end
      chk($sformatf("vec%0d_latency", v), lat, LAT + 1);
      chk($sformatf("vec%0d_data", v), rsp_o[tbl[v].id*FPWID +: FPWID], tbl[v].exp_o);
      tick();
      chk($sformatf("vec%0d_busy_clear", v), busy, 1'b0);
    end

    // Full contention: grants 0..3 back to back, responses in the same order.
    do_reset();
    req_a = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    req_valid = '1;
    for (int k = 0; k < NREQ; k++) begin
      settle();
      chk($sformatf("contend_grant%0d", k), req_ready, NREQ'(1) << k);
      tick();
    end
    req_valid = '0;
    tick();
    for (int k = 0; k < NREQ; k++) begin
      settle();
      chk($sformatf("contend_rsp%0d", k), rsp_valid, NREQ'(1) << k);
      tick();
    end

    // Back-pressure on requester 1 while everyone keeps requesting.
    do_reset();
    rsp_ready = 4'b1101;
    req_a = {32'h33333333, 32'h22222222, 32'hA5A50001, 32'h11111111};
    req_valid = '1;
    cnt_other = 0;
    for (int c = 0; c < 14; c++) begin
      settle();
      if (c >= 2) chk("bp_no_regrant", req_ready[1], 1'b0);
      if (rsp_valid[1]) chk("bp_rsp_stable", rsp_o[FPWID +: FPWID], 32'h5A5AFFFE);
      if ((req_ready & 4'b1101) != 0) cnt_other++;
      tick();
    end
    chk("bp_others_regranted", cnt_other > 3, 1'b1);
    rsp_ready = '1;
    req_valid = 4'b0010;
    settle();
    chk("bp_same_cycle_blocked", req_ready, 4'b0000);
    tick();
    settle();
    chk("bp_regrant_next", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    repeat (8) tick();

    // Fairness between two continuous requesters.
    do_reset();
    req_valid = 4'b1001;
    last = -1;
    ngr  = 0;
    for (int c = 0; c < 24; c++) begin
      settle();
      if (req_ready != 0) begin
        g = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        chk("fair_idx", (g == 0) || (g == 3), 1'b1);
        if (last >= 0) chk("fair_alternate", g != last, 1'b1);
        last = g;
        ngr++;
      end
      tick();
    end
    chk("fair_grant_count", ngr >= 4, 1'b1);
    req_valid = '0;
    repeat (8) tick();

    // Idle: nothing moves.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      settle();
      chk("idle", {sig_ce, req_ready, rsp_valid, busy}, '0);
      tick();
    end

    // Reset with two operations in flight.
    do_reset();
    req_a = {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A};
    req_valid = '1;
    settle();
    chk("rmf_grant0", req_ready, 4'b0001);
    tick();
    settle();
    chk("rmf_grant1", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rmf_async_zero", {req_ready, rsp_valid, sig_ce, busy, sig_a}, '0);
    chk("rmf_async_rsp_o", rsp_o, '0);
    tick();
    rst_n = 1'b1;
    req_valid = '1;
    settle();
    chk("rmf_first_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    for (int c = 0; c < 8; c++) begin
      settle();
      chk("rmf_no_stale_rsp", rsp_valid & 4'b1110, 4'b0000);
      tick();
    end

    // Random traffic checked by the scoreboard.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = NREQ'($urandom);
      req_a     = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (10) tick();
    settle();
    chk("drain_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
